// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The producer uses master; the serializer uses slave.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid,
        input  load_ready, so, so_valid, busy, done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, so, so_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with a valid/ready load port and gapless back-to-back frames.
// Defining PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             so_r, so_n;
    logic             sov_r, sov_n;
    logic             last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par, par_n;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The last frame cycle doubles as the load window for the next word.
    always_comb begin
`ifdef PISO_PARITY_EN
        last = (state == PARITY);
`else
        last = (state == SHIFT) && (cnt == LAST);
`endif
    end

    assign accept         = bus.load_valid && ((state == IDLE) || last);
    assign bus.load_ready = (state == IDLE) || last;
    assign bus.done       = last;
    assign bus.busy       = (state != IDLE);
    assign bus.so         = so_r;
    assign bus.so_valid   = sov_r;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        so_n    = 1'b0;
        sov_n   = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par;
`endif
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            so_n    = head(bus.din);
            sov_n   = 1'b1;
            sreg_n  = advance(bus.din);
`ifdef PISO_PARITY_EN
            par_n   = ^bus.din;
`endif
        end else begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
                        state_n = PARITY;
                        so_n    = par;
                        sov_n   = 1'b1;
`else
                        state_n = IDLE;
                        cnt_n   = '0;
`endif
                    end else begin
                        cnt_n  = cnt + 1'b1;
                        so_n   = head(sreg);
                        sov_n  = 1'b1;
                        sreg_n = advance(sreg);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
`endif
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            so_r  <= 1'b0;
            sov_r <= 1'b0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
            so_r  <= so_n;
            sov_r <= sov_n;
`ifdef PISO_PARITY_EN
            par   <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share one stimulus,
// a frame-index model checks every cycle, and literal streams pin the model.
module tb_piso_serializer;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    piso_serializer_if #(.WIDTH(W)) b1 ();
    piso_serializer_if #(.WIDTH(W)) b0 ();

    assign b1.din = din;
    assign b1.load_valid = load_valid;
    assign b0.din = din;
    assign b0.load_valid = load_valid;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Model: the frame in flight is the captured word plus an index (-1 when idle).
    int           idx = -1;
    logic [W-1:0] mword = '0;
    bit           mrdy;

    function automatic logic fbit(input logic [W-1:0] w, input bit msb, input int i);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            idx = -1;
        end else begin
            mrdy = (idx < 0) || (idx == FL - 1);
            if (mrdy && load_valid) begin
                mword = din;
                idx   = 0;
            end else if (idx >= 0 && idx < FL - 1) begin
                idx = idx + 1;
            end else begin
                idx = -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_so_msb",    b1.so,         (idx >= 0) ? fbit(mword, 1'b1, idx) : 1'b0);
        chk("m_so_lsb",    b0.so,         (idx >= 0) ? fbit(mword, 1'b0, idx) : 1'b0);
        chk("m_sov_msb",   b1.so_valid,   idx >= 0);
        chk("m_sov_lsb",   b0.so_valid,   idx >= 0);
        chk("m_busy_msb",  b1.busy,       idx >= 0);
        chk("m_busy_lsb",  b0.busy,       idx >= 0);
        chk("m_done_msb",  b1.done,       idx == FL - 1);
        chk("m_done_lsb",  b0.done,       idx == FL - 1);
        chk("m_ready_msb", b1.load_ready, (idx < 0) || (idx == FL - 1));
        chk("m_ready_lsb", b0.load_ready, (idx < 0) || (idx == FL - 1));
    end

    // Called at posedge+1 with the DUT ready; returns at posedge(k)+1.
    task automatic load(input logic [W-1:0] w);
        din = w;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    // Streams are written first-sent bit in bit 7.
    task automatic check_frame(input string n, input logic [W-1:0] sm, input logic [W-1:0] sl,
                               input logic par, input bit inject);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i < W) begin
                chk({n, "_so_msb"}, b1.so, sm[W-1-i]);
                chk({n, "_so_lsb"}, b0.so, sl[W-1-i]);
            end else begin
                chk({n, "_par_msb"}, b1.so, par);
                chk({n, "_par_lsb"}, b0.so, par);
            end
            chk({n, "_sov"}, b1.so_valid, 1'b1);
            chk({n, "_done"}, b1.done, i == FL - 1);
            if (inject && i == 2) begin
                @(posedge clk);
                #1 din = 8'hFF;
                load_valid = 1'b1;
            end
            if (inject && i == 3) begin
                chk({n, "_ready_lo"}, b1.load_ready, 1'b0);
                @(posedge clk);
                #1 load_valid = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string n);
        @(negedge clk);
        chk({n, "_idle_sov"}, b1.so_valid, 1'b0);
        chk({n, "_idle_so"}, b1.so, 1'b0);
        chk({n, "_idle_busy"}, b0.busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s2m = 16'hA53C;
    logic [15:0] s2l = 16'hA53C;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_so", b1.so, 1'b0);
        chk("rst_sov", b1.so_valid, 1'b0);
        chk("rst_busy", b1.busy, 1'b0);
        chk("rst_done", b1.done, 1'b0);
        chk("rst_ready", b1.load_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single frame from idle.
        load(8'hA5);
        check_frame("t1", 8'hA5, 8'hA5, 1'b0, 1'b0);
        check_idle("t1");

        // Back-to-back: 3C waits with load_valid held until the last frame cycle.
        din = 8'hA5;
        load_valid = 1'b1;
        @(posedge clk);
        #1 din = 8'h3C;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            if ((i % FL) < W) begin
                chk("t2_so_msb", b1.so, s2m[15 - ((i / FL) * W + (i % FL))]);
                chk("t2_so_lsb", b0.so, s2l[15 - ((i / FL) * W + (i % FL))]);
            end
            chk("t2_sov", b1.so_valid, 1'b1);
            chk("t2_busy", b1.busy, 1'b1);
            if (i == 3) chk("t2_ready_lo", b1.load_ready, 1'b0);
            if (i == FL - 1) begin
                chk("t2_ready_hi", b1.load_ready, 1'b1);
                @(posedge clk);
                #1 load_valid = 1'b0;
            end
        end
        check_idle("t2");

        // Load offered mid-frame is ignored.
        load(8'h4D);
        check_frame("t3", 8'h4D, 8'hB2, 1'b0, 1'b1);
        check_idle("t3");

        // Asynchronous reset during bit 4 discards the frame.
        load(8'hF0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_so", b1.so, 1'b0);
        chk("t4_rst_sov", b1.so_valid, 1'b0);
        chk("t4_rst_busy", b1.busy, 1'b0);
        chk("t4_rst_ready", b1.load_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        load(8'h81);
        check_frame("t4", 8'h81, 8'h81, 1'b0, 1'b0);
        check_idle("t4");

        // Bit order distinguishes the two instances.
        load(8'h01);
        check_frame("t5", 8'h01, 8'h80, 1'b1, 1'b0);
        check_idle("t5");

`ifdef PISO_PARITY_EN
        load(8'h07);
        check_frame("t6a", 8'h07, 8'hE0, 1'b1, 1'b0);
        check_idle("t6a");
        load(8'h03);
        check_frame("t6b", 8'h03, 8'hC0, 1'b0, 1'b0);
        check_idle("t6b");
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
